bcd_counter_arbiter: RTL and testbench
======================================

# bcd_counter_arbiter

Two-requester, round-robin arbiter that owns the single-digit BCD step counter and drives its seven-segment display. Each requester asks for one step operation (hold, +1, +2, -1) through a valid/ready handshake. The arbiter grants one requester at a time, applies the step modulo 10, then enforces a programmable hold-off before the next grant. It sits between the board-input front ends (switch/key logic) and the HEX display, so several input sources can share one counter.

## Interface

Parameters:
- HOLDOFF, default 2: idle cycles inserted after each executed op before the next grant; legal range 0–15.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_a_valid  input  1  requester A has an op pending.
- req_a_op  input  2  A's op: 00 hold, 01 +1, 10 +2, 11 -1.
- req_a_ready  output  1  A's op is accepted this cycle.
- req_b_valid  input  1  requester B has an op pending.
- req_b_op  input  2  B's op, same encoding.
- req_b_ready  output  1  B's op is accepted this cycle.
- grant  output  2  one-hot owner of the op in flight: bit0 = A, bit1 = B; 00 when none.
- busy  output  1  high in EXEC and HOLD.
- count  output  4  current BCD digit, always 0–9.
- HEX0  output  7  count decoded through the team's BCD_to_seven_segment.

## Operation

- States: IDLE, EXEC, HOLD.
- IDLE:
  - If only one requester is valid, that requester is selected.
  - If both are valid, the requester that was not granted last is selected.
  - The selected requester's ready is asserted combinationally in the same cycle.
  - A transfer happens on an edge where valid and ready are both high. On transfer: latch op, set grant, record last_grant, go to EXEC.
- EXEC (exactly 1 cycle): apply the latched op to count at the closing edge.
  - +1: 9 wraps to 0.
  - +2: 8 goes to 0; 9 goes to 1.
  - -1: 0 wraps to 9.
  - hold: count unchanged.
  - Next state is HOLD if HOLDOFF > 0, otherwise IDLE.
- HOLD: a down-counter loaded with HOLDOFF runs for HOLDOFF cycles, then the state returns to IDLE. grant clears on entry to HOLD.
- The hold op (00) still counts as a grant and updates last_grant, so a requester cannot starve the other by sending holds.
- Both ready outputs are 0 outside IDLE. Valid may change freely there and is ignored.
- All arithmetic is 4-bit. count never holds a value above 9.
- Ready depends only on state, both valids and last_grant, never on the op inputs.

## Timing

- Reset values (asserted asynchronously while reset_n = 0):
  - state = IDLE, count = 0, grant = 00, busy = 0, both ready = 0.
  - last_grant = B, so A wins the first tie.
  - HOLD counter = 0.
  - HEX0 = decode of 0.
- Latency: acceptance edge T0; count takes its new value after edge T1.
- Throughput: one op per 2 + HOLDOFF cycles.
- Reset mid-operation (in EXEC or HOLD) drops the latched op; count returns to 0 with no partial update.
- reset_n release is treated as synchronous to CLK by the board wrapper; the first grant can occur on the first edge after release.
- A requester that drops valid in the same cycle its ready rises has no transfer; the arbiter stays in IDLE and re-evaluates next cycle.

## Test plan

- Reset then A: A valid with op 01 and count = 9, HOLDOFF = 2 → req_a_ready = 1 at T0; count = 0 after T1; busy high for 3 cycles; HEX0 shows 0.
- Tie fairness: A and B both continuously valid with op 01, starting from count = 0 → grants alternate A, B, A, B; count reads 1, 2, 3, 4; ready edges spaced 4 cycles apart.
- +2 and -1 boundaries:
  - +2 from 8 → 0.
  - +2 from 9 → 1.
  - -1 from 0 → 9.
  - hold op from 5 → 5, and grant still toggles last_grant.
- HOLDOFF = 0: A continuously valid with op 11 from count = 3 → count reads 2, 1, 0, 9 on consecutive 2-cycle steps; ready never high during EXEC.
- Mid-op reset: assert reset_n = 0 during EXEC of a +1 from count 4 → count = 0 immediately; grant = 00; after release, first tie goes to A.
- Valid withdrawn: B valid for one IDLE cycle and deasserted before the edge → no transfer; count and last_grant unchanged.

Source files
------------

// File: rtl/bcd_counter_arbiter.sv
// Two-requester round-robin arbiter owning a single BCD step counter and
// its seven-segment display.
// Ports:
//   CLK, reset_n           clock, async active-low reset
//   req_a_valid/op/ready   requester A handshake (op: 00 hold, 01 +1, 10 +2, 11 -1)
//   req_b_valid/op/ready   requester B handshake, same encoding
//   grant                  one-hot owner of the op in EXEC (bit0 = A, bit1 = B)
//   busy                   high while in EXEC or HOLD
//   count                  current BCD digit 0..9
//   HEX0                   count as active-low segments {g,f,e,d,c,b,a}
module bcd_counter_arbiter #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       req_a_valid,
  input  logic [1:0] req_a_op,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [1:0] req_b_op,
  output logic       req_b_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic [3:0] count,
  output logic [6:0] HEX0
);

  localparam int unsigned CW = 4;
  localparam int unsigned HW = 4;
  localparam int unsigned OW = 2;
  localparam int unsigned SW = 7;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state, state_d;
  logic [OW-1:0]   op, op_d;
  logic [1:0]      grant_d;
  logic            last_b, last_b_d;
  logic [CW-1:0]   count_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            busy_d;
  logic [SW-1:0]   hex_d;
  logic            sel_a, sel_b;

  // Modulo-10 step of a BCD digit.
  function automatic logic [CW-1:0] step(input logic [CW-1:0] c, input logic [OW-1:0] o);
    case (o)
      2'b01:   step = (c == CW'(9)) ? CW'(0) : c + CW'(1);
      2'b10:   step = (c >= CW'(8)) ? c - CW'(8) : c + CW'(2);
      2'b11:   step = (c == CW'(0)) ? CW'(9) : c - CW'(1);
      default: step = c;
    endcase
  endfunction

  // Active-low seven-segment decode; non-BCD codes blank the digit.
  function automatic logic [SW-1:0] seg(input logic [CW-1:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Round-robin selection: on a tie the requester not granted last wins.
  always_comb begin
    sel_a       = req_a_valid & (~req_b_valid | last_b);
    sel_b       = req_b_valid & (~req_a_valid | ~last_b);
    req_a_ready = reset_n & (state == IDLE) & sel_a;
    req_b_ready = reset_n & (state == IDLE) & sel_b;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d  = state;
    op_d     = op;
    grant_d  = grant;
    last_b_d = last_b;
    count_d  = count;
    hold_d   = hold_cnt;
    case (state)
      IDLE: begin
        if (req_a_ready && req_a_valid) begin
          op_d     = req_a_op;
          grant_d  = 2'b01;
          last_b_d = 1'b0;
          state_d  = EXEC;
        end else if (req_b_ready && req_b_valid) begin
          op_d     = req_b_op;
          grant_d  = 2'b10;
          last_b_d = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        count_d = step(count, op);
        grant_d = 2'b00;
        if (HOLDOFF > 0) begin
          state_d = HOLD;
          hold_d  = HW'(HOLDOFF);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // Last hold cycle is the one that sees the counter at 1.
        if (hold_cnt <= HW'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_cnt - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    hex_d  = seg(count_d);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op       <= '0;
      grant    <= '0;
      last_b   <= 1'b1;
      count    <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      HEX0     <= seg(CW'(0));
    end else begin
      state    <= state_d;
      op       <= op_d;
      grant    <= grant_d;
      last_b   <= last_b_d;
      count    <= count_d;
      hold_cnt <= hold_d;
      busy     <= busy_d;
      HEX0     <= hex_d;
    end
  end

endmodule

// File: tb/tb_bcd_counter_arbiter.sv
module tb_bcd_counter_arbiter;

  typedef struct packed {
    logic [1:0] g;
    logic [3:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, a_ready, b_ready, busy;
  logic [1:0] a_op, b_op, grant;
  logic [3:0] count;
  logic [6:0] hex;
  logic       a0_valid, b0_valid, a0_ready, b0_ready, busy0;
  logic [1:0] a0_op, b0_op, grant0;
  logic [3:0] count0;
  logic [6:0] hex0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = -1;
  int   busy_run = 0;
  bit   mon_en = 1'b1;
  bit   space_en = 1'b0;
  bit   pend = 1'b0;
  logic [3:0] pend_c;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_counter_arbiter #(.HOLDOFF(2)) u_dut (
    .CLK(clk), .reset_n(rst_n),
    .req_a_valid(a_valid), .req_a_op(a_op), .req_a_ready(a_ready),
    .req_b_valid(b_valid), .req_b_op(b_op), .req_b_ready(b_ready),
    .grant(grant), .busy(busy), .count(count), .HEX0(hex)
  );

  bcd_counter_arbiter #(.HOLDOFF(0)) u_dut0 (
    .CLK(clk), .reset_n(rst_n),
    .req_a_valid(a0_valid), .req_a_op(a0_op), .req_a_ready(a0_ready),
    .req_b_valid(b0_valid), .req_b_op(b0_op), .req_b_ready(b0_ready),
    .grant(grant0), .busy(busy0), .count(count0), .HEX0(hex0)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor for the HOLDOFF=2 instance.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      busy_run = 0;
      pend     = 1'b0;
    end else if (mon_en) begin
      if (pend) begin
        chk("count", 32'(count), 32'(pend_c));
        chk("hex", 32'(hex), 32'(seg(pend_c)));
        pend = 1'b0;
      end
      if (grant != 2'b00) begin
        if (sb.size() == 0) begin
          chk("spurious_grant", 32'(grant), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("grant", 32'(grant), 32'(e.g));
          pend_c = e.c;
          pend   = 1'b1;
        end
      end
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        if (space_en && last_acc >= 0) chk("ready_spacing", 32'(cyc - last_acc), 32'(4));
        last_acc = cyc;
      end
      if (busy) busy_run++;
      else begin
        if (busy_run != 0) chk("busy_len", 32'(busy_run), 32'(3));
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !pend && !busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic push(input logic [1:0] eg, input logic [3:0] ec);
    exp_t e;
    e.g = eg;
    e.c = ec;
    sb.push_back(e);
  endtask

  task automatic do_op(input bit who_b, input logic [1:0] op, input logic [1:0] eg,
                       input logic [3:0] ec);
    bit ok = 1'b0;
    push(eg, ec);
    if (who_b) begin b_valid = 1'b1; b_op = op; end
    else begin a_valid = 1'b1; a_op = op; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who_b ? b_ready : a_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    drain();
  endtask

  task automatic tie(input int n);
    int got = 0;
    a_valid = 1'b1; b_valid = 1'b1; a_op = 2'b01; b_op = 2'b01;
    for (int i = 0; i < 100 && got < n; i++) begin
      @(negedge clk);
      if (a_ready || b_ready) got++;
    end
    if (got < n) chk("tie_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    drain();
  endtask

  task automatic op0(input logic [1:0] op);
    bit ok = 1'b0;
    a0_valid = 1'b1; a0_op = op;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a0_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("h0_accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    a0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp0 [4];
    bit ok;
    exp0[0] = 4'd2; exp0[1] = 4'd1; exp0[2] = 4'd0; exp0[3] = 4'd9;
    a_valid = 1'b1; b_valid = 1'b0; a_op = 2'b01; b_op = 2'b00;
    a0_valid = 1'b0; b0_valid = 1'b0; a0_op = 2'b00; b0_op = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready_a", 32'(a_ready), 32'(0));
    chk("rst_ready_b", 32'(b_ready), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_hex", 32'(hex), 32'(seg(4'd0)));
    a_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // HOLDOFF = 0: reach 3, then continuous -1 steps every 2 cycles.
    op0(2'b10);
    op0(2'b01);
    chk("h0_pre", 32'(count0), 32'(3));
    a0_valid = 1'b1; a0_op = 2'b11;
    @(negedge clk);
    chk("h0_ready", 32'(a0_ready), 32'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("h0_exec_ready", 32'(a0_ready), 32'(0));
      chk("h0_exec_grant", 32'(grant0), 32'(1));
      @(negedge clk);
      chk("h0_count", 32'(count0), 32'(exp0[i]));
      chk("h0_ready_again", 32'(a0_ready), 32'(1));
    end
    #1 a0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("h0_final", 32'(count0), 32'(9));

    // Reset then A, +1 wrap 9 -> 0.
    do_op(1'b0, 2'b11, 2'b01, 4'd9);
    do_op(1'b0, 2'b01, 2'b01, 4'd0);
    do_op(1'b1, 2'b00, 2'b10, 4'd0);

    // Tie fairness: alternating A, B with 4-cycle spacing.
    push(2'b01, 4'd1); push(2'b10, 4'd2); push(2'b01, 4'd3); push(2'b10, 4'd4);
    space_en = 1'b1; last_acc = -1;
    tie(4);
    space_en = 1'b0;

    // +2 / -1 boundaries and hold op.
    do_op(1'b0, 2'b10, 2'b01, 4'd6);
    do_op(1'b1, 2'b10, 2'b10, 4'd8);
    do_op(1'b0, 2'b10, 2'b01, 4'd0);
    do_op(1'b1, 2'b11, 2'b10, 4'd9);
    do_op(1'b0, 2'b10, 2'b01, 4'd1);
    do_op(1'b1, 2'b11, 2'b10, 4'd0);
    do_op(1'b0, 2'b11, 2'b01, 4'd9);
    do_op(1'b1, 2'b10, 2'b10, 4'd1);
    do_op(1'b0, 2'b10, 2'b01, 4'd3);
    do_op(1'b1, 2'b10, 2'b10, 4'd5);
    do_op(1'b0, 2'b00, 2'b01, 4'd5);
    push(2'b10, 4'd6);
    tie(1);

    // B withdraws valid before the edge: no transfer.
    b_valid = 1'b1; b_op = 2'b01;
    @(negedge clk);
    chk("wd_ready", 32'(b_ready), 32'(1));
    #1 b_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("wd_count", 32'(count), 32'(6));
    chk("wd_busy", 32'(busy), 32'(0));
    push(2'b01, 4'd7);
    tie(1);

    // Mid-op reset during EXEC of +1 from 4.
    do_op(1'b1, 2'b11, 2'b10, 4'd6);
    do_op(1'b0, 2'b11, 2'b01, 4'd5);
    do_op(1'b1, 2'b11, 2'b10, 4'd4);
    chk("pre_mid", 32'(count), 32'(4));
    mon_en = 1'b0;
    a_valid = 1'b1; a_op = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("mid_accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("mid_grant", 32'(grant), 32'(1));
    chk("mid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_count", 32'(count), 32'(0));
    chk("mid_grant_clr", 32'(grant), 32'(0));
    chk("mid_busy_clr", 32'(busy), 32'(0));
    chk("mid_hex", 32'(hex), 32'(seg(4'd0)));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    push(2'b01, 4'd1);
    tie(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
